// File: rtl/baggage_drop_ctrl.sv
// -----------------------------------------------------------------------------
// baggage_drop_ctrl
//
// Sequential controller for the baggage-drop datapath. Per request it latches
// the four height sensors, averages them, takes an 8-step restoring square
// root of {height, 8'h00} (sqrt(height) in Q4.4), halves it into the fall
// time t_act, compares that against t_lim under drop_en, and then holds
// drop_activated high for DROP_CYCLES cycles on an accepted drop.
//
// Optional feature: define BAGGAGE_SENSOR_FAULT_EN to reject any request whose
// sensors read 8'h00 or 8'hFF (flagged on fault). Without it fault is tied 0.
//
// Parameters:
//   DROP_CYCLES     cycles drop_activated stays high (1..65535)
// Ports:
//   clk             single clock, rising edge
//   rst_n           asynchronous active-low reset
//   req             start request, sampled only in IDLE
//   sensor1..4[7:0] raw heights, latched in SAMPLE
//   t_lim[15:0]     time limit, sampled in COMPARE
//   drop_en         drop enable, sampled in COMPARE
//   busy            high in every state except IDLE
//   valid           one-cycle pulse when t_act is updated
//   t_act[15:0]     computed fall time, held until the next valid
//   drop_activated  drop actuator strobe
//   status[1:0]     0 idle, 1 computing, 2 dropped, 3 rejected
//   fault           sensor fault flag
// -----------------------------------------------------------------------------
module baggage_drop_ctrl #(
  parameter int unsigned DROP_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [7:0]  sensor1,
  input  logic [7:0]  sensor2,
  input  logic [7:0]  sensor3,
  input  logic [7:0]  sensor4,
  input  logic [15:0] t_lim,
  input  logic        drop_en,
  output logic        busy,
  output logic        valid,
  output logic [15:0] t_act,
  output logic        drop_activated,
  output logic [1:0]  status,
  output logic        fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_ROOT,
    S_COMPARE,
    S_DROP,
    S_REJECT
  } state_e;

  localparam logic [15:0] DROP_LOAD = 16'(DROP_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] rad_q, rad_d;     // radicand, consumed two bits per ROOT cycle
  logic [7:0]  root_q, root_d;   // partial root, one bit appended per cycle
  logic [9:0]  rem_q, rem_d;     // partial remainder, never exceeds 2*root
  logic [2:0]  iter_q, iter_d;
  logic [15:0] hold_q, hold_d;   // remaining DROP cycles
  logic [15:0] t_act_q, t_act_d;
  logic        valid_q, valid_d;
  logic [1:0]  status_q, status_d;

  logic [9:0]  sum;
  logic [7:0]  height;
  logic [11:0] rem_trial;
  logic [11:0] trial;
  logic [11:0] rem_diff;
  logic        trial_fits;
  logic [15:0] t_act_new;

`ifdef BAGGAGE_SENSOR_FAULT_EN
  logic fault_q, fault_d;
  logic sensor_bad;

  // 8'h00 and 8'hFF are a disconnected or saturated sensor.
  assign sensor_bad = (sensor1 == 8'h00) || (sensor1 == 8'hFF) ||
                      (sensor2 == 8'h00) || (sensor2 == 8'hFF) ||
                      (sensor3 == 8'h00) || (sensor3 == 8'hFF) ||
                      (sensor4 == 8'h00) || (sensor4 == 8'hFF);
`endif

  // Average of the four sensors, truncating.
  assign sum    = {2'b00, sensor1} + {2'b00, sensor2} + {2'b00, sensor3} + {2'b00, sensor4};
  assign height = sum[9:2];

  // One restoring step: bring down the next bit pair and try to subtract
  // (4*root + 1); success means the next root bit is 1.
  assign rem_trial  = {rem_q, rad_q[15:14]};
  assign trial      = {2'b00, root_q, 2'b01};
  assign trial_fits = (rem_trial >= trial);
  assign rem_diff   = rem_trial - trial;

  // Q4.4 root halved gives the fall time.
  assign t_act_new = {9'd0, root_q[7:1]};

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    rad_d    = rad_q;
    root_d   = root_q;
    rem_d    = rem_q;
    iter_d   = iter_q;
    hold_d   = hold_q;
    t_act_d  = t_act_q;
    valid_d  = 1'b0;
    status_d = status_q;
`ifdef BAGGAGE_SENSOR_FAULT_EN
    fault_d  = fault_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d  = S_SAMPLE;
          status_d = 2'd1;
`ifdef BAGGAGE_SENSOR_FAULT_EN
          fault_d  = 1'b0;
`endif
        end
      end

      S_SAMPLE: begin
        rad_d   = {height, 8'h00};
        root_d  = '0;
        rem_d   = '0;
        iter_d  = '0;
        state_d = S_ROOT;
`ifdef BAGGAGE_SENSOR_FAULT_EN
        if (sensor_bad) begin
          fault_d  = 1'b1;
          status_d = 2'd3;
          state_d  = S_REJECT;
        end
`endif
      end

      S_ROOT: begin
        rad_d  = {rad_q[13:0], 2'b00};
        root_d = {root_q[6:0], trial_fits};
        rem_d  = trial_fits ? rem_diff[9:0] : rem_trial[9:0];
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) begin
          state_d = S_COMPARE;
        end
      end

      S_COMPARE: begin
        t_act_d = t_act_new;
        valid_d = 1'b1;
        if (drop_en && (t_act_new <= t_lim)) begin
          hold_d   = DROP_LOAD;
          status_d = 2'd2;
          state_d  = S_DROP;
        end else begin
          status_d = 2'd3;
          state_d  = S_REJECT;
        end
      end

      S_DROP: begin
        hold_d = hold_q - 16'd1;
        if (hold_q <= 16'd1) begin
          state_d = S_IDLE;
        end
      end

      S_REJECT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rad_q    <= '0;
      root_q   <= '0;
      rem_q    <= '0;
      iter_q   <= '0;
      hold_q   <= '0;
      t_act_q  <= '0;
      valid_q  <= 1'b0;
      status_q <= 2'd0;
`ifdef BAGGAGE_SENSOR_FAULT_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rad_q    <= rad_d;
      root_q   <= root_d;
      rem_q    <= rem_d;
      iter_q   <= iter_d;
      hold_q   <= hold_d;
      t_act_q  <= t_act_d;
      valid_q  <= valid_d;
      status_q <= status_d;
`ifdef BAGGAGE_SENSOR_FAULT_EN
      fault_q  <= fault_d;
`endif
    end
  end

  // busy and drop_activated decode only the state register, so reset drops
  // them asynchronously and no input can reach them combinationally.
  assign busy           = (state_q != S_IDLE);
  assign drop_activated = (state_q == S_DROP);
  assign valid          = valid_q;
  assign t_act          = t_act_q;
  assign status         = status_q;
`ifdef BAGGAGE_SENSOR_FAULT_EN
  assign fault          = fault_q;
`else
  assign fault          = 1'b0;
`endif

endmodule

// File: tb/tb_baggage_drop_ctrl.sv
// -----------------------------------------------------------------------------
// tb_baggage_drop_ctrl
//
// Scoreboard bench for baggage_drop_ctrl. The driver pushes the expected fall
// time, drop decision and request edge for every request; a monitor pops on
// each valid pulse and follows the transaction to completion (drop pulse
// length, final status, latency). The reference computes the result from the
// arithmetic definition: integer average, then the largest r with r*r not
// exceeding height*256, then r/2.
// -----------------------------------------------------------------------------
module tb_baggage_drop_ctrl;

  localparam int N = 16;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [7:0]  sensor1, sensor2, sensor3, sensor4;
  logic [15:0] t_lim;
  logic        drop_en;
  logic        busy;
  logic        valid;
  logic [15:0] t_act;
  logic        drop_activated;
  logic [1:0]  status;
  logic        fault;

  baggage_drop_ctrl #(.DROP_CYCLES(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .sensor1       (sensor1),
    .sensor2       (sensor2),
    .sensor3       (sensor3),
    .sensor4       (sensor4),
    .t_lim         (t_lim),
    .drop_en       (drop_en),
    .busy          (busy),
    .valid         (valid),
    .t_act         (t_act),
    .drop_activated(drop_activated),
    .status        (status),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] t;
    bit          drop;
    int          e0;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_t(input int s1, input int s2, input int s3, input int s4);
    int h, rad, r;
    h   = (s1 + s2 + s3 + s4) / 4;
    rad = h * 256;
    r   = 0;
    while ((r + 1) * (r + 1) <= rad) r++;
    return 16'(r / 2);
  endfunction

  // ---------------------------------------------------------------- monitor
  exp_t cur;
  bit   have_cur  = 0;
  bit   prev_busy = 0;
  int   drop_run  = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      have_cur  = 0;
      drop_run  = 0;
      prev_busy = 0;
    end else begin
      if (valid) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_valid t_act=%0d expected no valid", t_act);
        end else begin
          cur      = q.pop_front();
          have_cur = 1;
          drop_run = 0;
          check("t_act", t_act, cur.t);
          check("valid_latency", cyc - cur.e0, 10);
          check("busy_at_valid", busy, 1);
        end
      end
      if (drop_activated) drop_run++;
      if (have_cur && prev_busy && !busy) begin
        check("final_status", status, cur.drop ? 2 : 3);
        check("drop_pulse_len", drop_run, cur.drop ? N : 0);
        check("idle_latency", cyc - cur.e0, cur.drop ? 10 + N : 11);
        have_cur = 0;
      end
      prev_busy = busy;
    end
  end

  // ----------------------------------------------------------------- driver
  task automatic issue(input int s1, input int s2, input int s3, input int s4,
                       input logic [15:0] tl, input logic de, input bit extra_req);
    exp_t e;
    @(negedge clk);
    sensor1 = 8'(s1); sensor2 = 8'(s2); sensor3 = 8'(s3); sensor4 = 8'(s4);
    t_lim   = tl;
    drop_en = de;
    e.t     = model_t(s1, s2, s3, s4);
    e.drop  = de && (e.t <= tl);
    e.e0    = cyc + 1;
    q.push_back(e);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    // Sensors are latched by now; disturbing them must not matter.
    sensor1 = 8'($urandom); sensor2 = 8'($urandom);
    sensor3 = 8'($urandom); sensor4 = 8'($urandom);
    if (extra_req) begin
      repeat (2) @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
    end
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy) begin
        done = 1;
        break;
      end
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL wait_idle busy=1 expected busy=0 within 100 cycles");
    end
    @(negedge clk);
  endtask

  task automatic run(input int s1, input int s2, input int s3, input int s4,
                     input logic [15:0] tl, input logic de, input bit extra_req);
    issue(s1, s2, s3, s4, tl, de, extra_req);
    wait_idle();
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    req = 1'b0;
    sensor1 = '0; sensor2 = '0; sensor3 = '0; sensor4 = '0;
    t_lim = '0;
    drop_en = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_t_act", t_act, 0);
    check("rst_drop", drop_activated, 0);
    check("rst_status", status, 0);
    check("rst_fault", fault, 0);
    #2 rst_n = 1'b1;

    // Nominal accept and the boundary one below it.
    run(100, 100, 100, 100, 16'd80, 1'b1, 0);
    run(100, 100, 100, 100, 16'd79, 1'b1, 0);
`ifndef BAGGAGE_SENSOR_FAULT_EN
    run(255, 255, 255, 255, 16'hFFFF, 1'b0, 0);
    run(0, 0, 0, 0, 16'd0, 1'b1, 0);
`endif
    // Extra request during ROOT must be ignored.
    run(10, 20, 30, 41, 16'd50, 1'b1, 1);

    // Reset during the fifth DROP cycle.
    issue(100, 100, 100, 100, 16'd200, 1'b1, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (drop_activated) begin
        seen = 1;
        break;
      end
    end
    check("drop_started", seen, 1);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_drop", drop_activated, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_status", status, 0);
    check("rst_mid_t_act", t_act, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    run(60, 70, 80, 90, 16'd100, 1'b1, 0);

    // Back-to-back with req held high.
    begin
      exp_t e;
      @(negedge clk);
      sensor1 = 8'd50; sensor2 = 8'd60; sensor3 = 8'd70; sensor4 = 8'd80;
      t_lim = 16'd1000;
      drop_en = 1'b1;
      e.t = model_t(50, 60, 70, 80);
      e.drop = 1;
      e.e0 = cyc + 1;
      q.push_back(e);
      req = 1'b1;
      @(negedge clk);
      wait_idle_hold: for (int i = 0; i < 100; i++) begin
        if (!busy) break;
        @(negedge clk);
      end
      e.e0 = cyc + 1;
      q.push_back(e);
      @(negedge clk);
      req = 1'b0;
      wait_idle();
    end

    // Randomized requests.
    for (int k = 0; k < 20; k++) begin
`ifdef BAGGAGE_SENSOR_FAULT_EN
      run($urandom_range(1, 254), $urandom_range(1, 254), $urandom_range(1, 254),
          $urandom_range(1, 254), 16'($urandom_range(0, 140)),
          ($urandom_range(0, 3) != 0), 0);
`else
      run($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
          $urandom_range(0, 255), 16'($urandom_range(0, 140)),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0));
`endif
    end

`ifdef BAGGAGE_SENSOR_FAULT_EN
    begin
      logic [15:0] prev_t;
      prev_t = t_act;
      @(negedge clk);
      sensor1 = 8'd100; sensor2 = 8'd100; sensor3 = 8'd0; sensor4 = 8'd100;
      t_lim = 16'hFFFF;
      drop_en = 1'b1;
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (2) @(negedge clk);
      check("fault_flag", fault, 1);
      check("fault_status", status, 3);
      check("fault_t_act", t_act, prev_t);
      wait_idle();
    end
`endif

    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/baggage_drop_ctrl.md
# baggage_drop_ctrl

- Sequential controller for the baggage-drop datapath.
- Per request it:
  - latches the four height sensors;
  - averages them;
  - runs an 8-iteration restoring square root;
  - derives the fall time `t_act`;
  - compares it against `t_lim` under `drop_en`;
  - times the `drop_activated` pulse.
- Sits between the sensor inputs and the seven-segment display stage, which consumes `t_act` and `status`.

## Interface
- `DROP_CYCLES`, default 16: cycles `drop_activated` is held high on an accepted drop; legal range 1..65535.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input 1: start request, sampled only in IDLE.
- `sensor1`..`sensor4` input 8 each: raw heights, latched in SAMPLE.
- `t_lim` input 16: time limit, sampled in COMPARE.
- `drop_en` input 1: drop enable, sampled in COMPARE.
- `busy` output 1: high in every state except IDLE.
- `valid` output 1: one-cycle pulse when `t_act` is updated.
- `t_act` output 16: computed fall time, held until the next `valid`.
- `drop_activated` output 1: drop actuator strobe.
- `status` output 2: 0 idle/none, 1 computing, 2 dropped, 3 rejected; held until the next request.
- `fault` output 1: sensor fault flag; constant 0 unless the macro below is defined.

## Operation
States: IDLE, SAMPLE, ROOT, COMPARE, DROP, REJECT.
- **IDLE**
  - `req`=1 → SAMPLE; `status`←1, `fault`←0.
- **SAMPLE**
  - `sum` = `sensor1`+`sensor2`+`sensor3`+`sensor4` (10 bits).
  - `height` = `sum`>>2 (8 bits, truncating).
  - Radicand = {`height`, 8'h00} (16 bits).
  - Clear root/remainder registers and the iteration counter → ROOT.
- **ROOT**
  - Restoring bit-pair square root, one result bit per cycle, MSB first.
  - Exactly 8 cycles.
  - Result `r` = floor(sqrt(radicand)), 8 bits, i.e. sqrt(`height`) in Q4.4.
  - After the 8th iteration → COMPARE.
- **COMPARE**
  - `t_act` ← {8'h00, `r`} >> 1; `valid`=1 for this cycle only.
  - If `drop_en`=1 and `t_act` <= `t_lim` (16-bit unsigned compare, using the new `t_act`) → DROP, load the hold counter with `DROP_CYCLES`.
  - Otherwise → REJECT.
- **DROP**
  - `drop_activated`=1, `status`=2.
  - Counter decrements each cycle; at 1 → IDLE.
- **REJECT**
  - One cycle, `status`←3 → IDLE.
- **Ignored inputs**
  - `req` outside IDLE is ignored; no queueing.
  - Sensor changes after SAMPLE do not affect the running computation.
  - `drop_en`/`t_lim` are observed only in COMPARE.
- **Registered outputs**
  - All outputs are registered.
  - `busy` and `drop_activated` decode from the state register with no combinational input path.

## Timing
- **Reset** (asynchronous assert, synchronous deassert by the clock domain): state=IDLE, `t_act`=0, `valid`=0, `drop_activated`=0, `busy`=0, `status`=0, `fault`=0, all internal registers 0.
- **Reset mid-operation:** an in-flight computation or drop pulse is aborted immediately; `drop_activated` falls asynchronously.
- **Request-to-result** (`req` sampled high at edge E0):
  - E1: SAMPLE.
  - E2..E9: ROOT.
  - E10: COMPARE; `valid` and new `t_act` visible after E10 for one cycle.
  - E11: DROP begins; `drop_activated` high for exactly `DROP_CYCLES` cycles.
  - Accepted-drop path: `busy` falls and IDLE is re-entered DROP_CYCLES cycles after E11.
  - Reject path: REJECT at E11, IDLE at E12.
- **Back-to-back:** `req` held high continuously re-triggers on the first IDLE cycle after each completion.

## Configuration
- Macro: `BAGGAGE_SENSOR_FAULT_EN`.
- **Defined:**
  - In SAMPLE, if any sensor equals 8'h00 or 8'hFF: `fault`←1, ROOT/COMPARE are skipped, go directly to REJECT.
  - `valid` does not pulse and `t_act` is unchanged.
  - `fault` holds until the next accepted `req`.
- **Undefined:**
  - No check; `fault` is tied 0.
  - All sensor values are processed normally.

## Test plan
- All sensors 100, `t_lim`=80, `drop_en`=1, `req` pulse:
  - `valid` at E10 with `t_act`=80 (radicand 25600, `r`=160).
  - `drop_activated` high for 16 cycles; `status`=2.
- Same sensors, `t_lim`=79: `t_act`=80, no drop, `status`=3, `busy` low at E12.
- All sensors 255, `drop_en`=0, `t_lim`=16'hFFFF: `t_act`=127 (`r`=255), REJECT, `drop_activated` never asserts.
- Sensors 10/20/30/41 (sum 101, `height`=25), `req` repeated during ROOT:
  - Only one `valid`; `t_act`=40 (`r`=80).
  - Extra `req` ignored.
- `rst_n` low during DROP cycle 5:
  - `drop_activated` drops immediately; all outputs reset.
  - Next `req` runs a full 10-cycle sequence.
- With `BAGGAGE_SENSOR_FAULT_EN`, `sensor3`=0: `fault`=1, `status`=3 at E2, no `valid`, `t_act` keeps its previous value.
